ws2812b_bit_encoder: RTL and testbench

//   Serialises one 24-bit WS2812B pixel word onto the single-wire LED strip

---
 rtl/ws2812b_bit_encoder.sv | 116 +++++++++++
 tb/tb_ws2812b_bit_encoder.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/ws2812b_bit_encoder.sv
// WS2812B single-wire serialiser: one 24-bit GRB pixel per handshake,
// optional strip latch (long low) after the last bit.
module ws2812b_bit_encoder #(
  parameter int BIT_CYCLES   = 80,
  parameter int T0H_CYCLES   = 26,
  parameter int T1H_CYCLES   = 51,
  parameter int RESET_CYCLES = 18000,
  parameter int CNT_W        = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] data_in,
  input  logic        valid,
  input  logic        latch,
  output logic        ready,
  output logic        led
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    LATCH = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] T0H      = CNT_W'(T0H_CYCLES);
  localparam logic [CNT_W-1:0] T1H      = CNT_W'(T1H_CYCLES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [4:0]       bit_idx_q, bit_idx_d;
  logic [23:0]      shift_q, shift_d;
  logic             latch_q, latch_d;
  logic             led_q, led_d;
  logic             ready_q, ready_d;

  logic [CNT_W-1:0] cyc_inc;
  logic [CNT_W-1:0] th;

  assign cyc_inc = cyc_q + 1'b1;
  assign th      = shift_q[23] ? T1H : T0H;

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    latch_d   = latch_q;
    led_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (valid) begin
          shift_d   = data_in;
          latch_d   = latch;
          bit_idx_d = 5'd23;
          cyc_d     = '0;
          state_d   = SEND;
          led_d     = 1'b1;
        end
      end
      SEND: begin
        if (cyc_q == BIT_LAST) begin
          cyc_d = '0;
          if (bit_idx_q != 5'd0) begin
            shift_d   = {shift_q[22:0], 1'b0};
            bit_idx_d = bit_idx_q - 5'd1;
            led_d     = 1'b1;
          end else begin
            state_d = latch_q ? LATCH : IDLE;
          end
        end else begin
          cyc_d = cyc_inc;
          led_d = (cyc_inc < th);
        end
      end
      LATCH: begin
        if (cyc_q == RST_LAST) begin
          cyc_d   = '0;
          state_d = IDLE;
        end else begin
          cyc_d = cyc_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cyc_d   = '0;
      end
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cyc_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      latch_q   <= 1'b0;
      led_q     <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      latch_q   <= latch_d;
      led_q     <= led_d;
      ready_q   <= ready_d;
    end
  end

  assign ready = ready_q;
  assign led   = led_q;

endmodule

// File: tb/tb_ws2812b_bit_encoder.sv
// Bench for ws2812b_bit_encoder: per-cycle {ready,led} compared against
// a pixel-timeline model computed from elapsed cycles since accept.
module tb_ws2812b_bit_encoder;

  localparam int BITC = 80;
  localparam int T0   = 26;
  localparam int T1   = 51;
  localparam int RSTC = 18000;
  localparam int FRM  = 24 * BITC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] data_in = '0;
  logic        valid = 1'b0;
  logic        latch = 1'b0;
  logic        ready;
  logic        led;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  ws2812b_bit_encoder dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_in (data_in),
    .valid   (valid),
    .latch   (latch),
    .ready   (ready),
    .led     (led)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [1:0] obs,
                       input logic [1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got {ready,led}=%b want %b",
               tag, $time, obs, exp);
    end
  endtask

  // Model: a pixel is a timeline of k cycles since the accept edge.
  bit          m_busy = 1'b0;
  int          m_k = 0;
  int          m_total = 0;
  logic [23:0] m_data = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy = 1'b0;
    end else if (m_busy) begin
      m_k++;
      if (m_k >= m_total) m_busy = 1'b0;
    end else if (valid) begin
      m_busy  = 1'b1;
      m_k     = 0;
      m_data  = data_in;
      m_total = FRM + (latch ? RSTC : 0);
    end
  end

  function automatic logic [1:0] model_out();
    int b, pos, hi;
    if (!m_busy) return 2'b10;
    if (m_k < FRM) begin
      b   = m_k / BITC;
      pos = m_k % BITC;
      hi  = m_data[23 - b] ? T1 : T0;
      return {1'b0, logic'(pos < hi)};
    end
    return 2'b00;
  endfunction

  always @(negedge clk) begin
    if (chk_en) check("wave", {ready, led}, model_out());
  end

  task automatic send(input logic [23:0] d, input logic l);
    valid   = 1'b1;
    data_in = d;
    latch   = l;
    @(negedge clk);
    valid   = 1'b0;
    latch   = 1'b0;
    data_in = 24'($urandom);
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (ready !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) check("timeout", {1'b0, ready}, 2'b01);
  endtask

  task automatic junk_pulse();
    valid   = 1'b1;
    data_in = 24'($urandom);
    latch   = 1'($urandom);
    @(negedge clk);
    valid   = 1'b0;
    latch   = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    rst_n  = 1'b1;
    repeat (1000) @(negedge clk);

    send(24'hAA00FF, 1'b0);
    wait_ready(FRM + 10);
    repeat (3) @(negedge clk);

    send(24'h000001, 1'b1);
    wait_ready(FRM + RSTC + 10);
    repeat (3) @(negedge clk);

    send(24'h5A3C96, 1'b0);
    repeat (10 * BITC + 30) @(negedge clk);
    send(24'hFFFFFF, 1'b1);
    wait_ready(FRM + 10);
    repeat (5) @(negedge clk);

    send(24'h123456, 1'b1);
    repeat (5 * BITC + 10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_mid", {ready, led}, 2'b10);
    repeat (2) @(negedge clk);
    send(24'hFFFFFF, 1'b0);
    wait_ready(FRM + 10);

    send(24'h00FF00, 1'b0);
    wait_ready(FRM + 10);
    send(24'hC0FFEE, 1'b0);
    wait_ready(FRM + 10);
    send(24'h81A5E7, 1'b1);
    wait_ready(FRM + RSTC + 10);

    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      send(24'($urandom), 1'b0);
      repeat ($urandom_range(0, 3)) begin
        repeat ($urandom_range(1, 600)) @(negedge clk);
        junk_pulse();
      end
      wait_ready(FRM + 10);
    end

    repeat (20) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
